// File: rtl/cnn_3d_dense_layer_if.sv
// Handshake and data bundle between the dense classifier and its environment.
// The master side drives start and the operand arrays; the slave side returns the results.
interface cnn_3d_dense_layer_if #(
  parameter int NUM_INPUTS  = 24,
  parameter int NUM_CLASSES = 4,
  parameter int IDX_W       = 2
);
  logic                start;
  logic signed [15:0]  pool_result  [NUM_INPUTS];
  logic signed [15:0]  weights      [NUM_CLASSES*NUM_INPUTS];
  logic signed [15:0]  biases       [NUM_CLASSES];
  logic signed [15:0]  dense_result [NUM_CLASSES];
  logic [IDX_W-1:0]    class_idx;
  logic                busy;
  logic                done;

  modport master (
    output start, pool_result, weights, biases,
    input  dense_result, class_idx, busy, done
  );

  modport slave (
    input  start, pool_result, weights, biases,
    output dense_result, class_idx, busy, done
  );
endinterface

// File: rtl/cnn_3d_dense_layer.sv
// Dense classifier stage: one time-multiplexed MAC computes every class score, saturates it and tracks the argmax.
// Optional macro DENSE_RELU_EN clamps negative class scores to zero before they are stored and compared.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | load accumulator with the shifted bias of class c
// MAC    | accumulate one feature*weight product per cycle
// STORE  | shift, saturate, write dense_result[c], update argmax
// FINISH | last class written; done follows on the next cycle
module cnn_3d_dense_layer #(
  parameter int POOL_OUT_SIZE = 2,
  parameter int NUM_FILTERS   = 3,
  parameter int NUM_CLASSES   = 4,
  parameter int FRAC_BITS     = 8,
  parameter int ACC_WIDTH     = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  cnn_3d_dense_layer_if.slave      dense_if
);

  localparam int NUM_INPUTS = POOL_OUT_SIZE * POOL_OUT_SIZE * POOL_OUT_SIZE * NUM_FILTERS;
  localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int W_W        = (NUM_CLASSES * NUM_INPUTS > 1) ? $clog2(NUM_CLASSES * NUM_INPUTS) : 1;

  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_STORE, S_FINISH} state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]            i_q;
  logic [IDX_W-1:0]            c_q;
  logic signed [15:0]          max_q;
  logic [IDX_W-1:0]            class_idx_q;
  logic signed [15:0]          dense_q [NUM_CLASSES];

  logic [W_W-1:0]              w_idx;
  logic signed [15:0]          bias_c;
  logic signed [31:0]          prod;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] r_shift;
  logic signed [15:0]          r_fin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (dense_if.start) state_d = S_INIT;
      S_INIT:   state_d = S_MAC;
      S_MAC:    if (i_q == LAST_I) state_d = S_STORE;
      S_STORE:  state_d = (c_q == LAST_C) ? S_FINISH : S_INIT;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered, so they trail the state by one cycle.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_INIT, S_MAC, S_STORE: busy_d = 1'b1;
      S_FINISH:               done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_idx    = W_W'(int'(c_q) * NUM_INPUTS + int'(i_q));
    bias_c   = dense_if.biases[c_q];
    prod     = dense_if.pool_result[i_q] * dense_if.weights[w_idx];
    bias_ext = {{(ACC_WIDTH-16){bias_c[15]}}, bias_c} <<< FRAC_BITS;
    prod_ext = {{(ACC_WIDTH-32){prod[31]}}, prod};
    r_shift  = acc_q >>> FRAC_BITS;
    if (r_shift > SAT_MAX)      r_fin = 16'sh7FFF;
    else if (r_shift < SAT_MIN) r_fin = 16'sh8000;
    else                        r_fin = r_shift[15:0];
`ifdef DENSE_RELU_EN
    if (r_fin < 16'sd0) r_fin = 16'sd0;
`else
    r_fin = r_fin;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      i_q         <= '0;
      c_q         <= '0;
      max_q       <= '0;
      class_idx_q <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) dense_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (dense_if.start) c_q <= '0;
        S_INIT: begin
          acc_q <= bias_ext;
          i_q   <= '0;
        end
        S_MAC: begin
          acc_q <= acc_q + prod_ext;
          i_q   <= i_q + 1'b1;
        end
        S_STORE: begin
          dense_q[c_q] <= r_fin;
          // Strict compare: ties keep the lower class index.
          if (c_q == '0) begin
            max_q       <= r_fin;
            class_idx_q <= '0;
          end else if (r_fin > max_q) begin
            max_q       <= r_fin;
            class_idx_q <= c_q;
          end
          if (c_q != LAST_C) c_q <= c_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dense_if.dense_result = dense_q;
  assign dense_if.class_idx    = class_idx_q;
  assign dense_if.busy         = busy_q;
  assign dense_if.done         = done_q;

endmodule

// File: tb/tb_cnn_3d_dense_layer.sv
// Directed bench for cnn_3d_dense_layer: hand-computed class scores, argmax, done/busy timing and reset abort.
module tb_cnn_3d_dense_layer;

  localparam int NI  = 24;
  localparam int NC  = 4;
  localparam int LAT = 1 + NC * (NI + 2);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cnn_3d_dense_layer_if #(.NUM_INPUTS(NI), .NUM_CLASSES(NC), .IDX_W(2)) dut_if ();

  cnn_3d_dense_layer #(
    .POOL_OUT_SIZE(2), .NUM_FILTERS(3), .NUM_CLASSES(NC), .FRAC_BITS(8), .ACC_WIDTH(40)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .dense_if (dut_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input int k, input logic [15:0] exp);
    chk($sformatf("dense[%0d]", k), {16'h0, dut_if.dense_result[k]}, {16'h0, exp});
  endtask

  task automatic fill(input logic [15:0] p, input logic [15:0] w, input logic [15:0] b);
    for (int k = 0; k < NI; k++) dut_if.pool_result[k] = p;
    for (int k = 0; k < NI*NC; k++) dut_if.weights[k] = w;
    for (int k = 0; k < NC; k++) dut_if.biases[k] = b;
  endtask

  // One run from IDLE; optionally pulses start again so that it is sampled at edge extra_edge.
  task automatic do_run(input string tag, input int extra_edge);
    int done_edge = -1;
    int done_cnt  = 0;
    int busy_bad  = 0;
    @(negedge clk);
    dut_if.start = 1'b1;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    if (dut_if.busy !== 1'b0) busy_bad++;
    for (int e = 1; e <= LAT + 35; e++) begin
      if (e == extra_edge) dut_if.start = 1'b1;
      @(posedge clk);
      #1;
      if (e == extra_edge) dut_if.start = 1'b0;
      if (dut_if.done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (dut_if.busy !== ((e >= 1) && (e <= LAT - 1))) busy_bad++;
    end
    chk({tag, "_done_edge"}, done_edge, LAT);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    int dcnt;
    int d_first;
    int d_second;
    dut_if.start = 1'b0;
    fill(16'h0000, 16'h0000, 16'h0000);

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) chk_d(k, 16'h0000);
    chk("rst_class_idx", dut_if.class_idx, 0);
    chk("rst_busy", dut_if.busy, 0);
    chk("rst_done", dut_if.done, 0);
    @(negedge clk) reset = 1'b0;

    // 24 * 1.0 * 1.0 = 24.0
    fill(16'h0100, 16'h0100, 16'h0000);
    do_run("ones", -1);
    for (int k = 0; k < NC; k++) chk_d(k, 16'h1800);
    chk("ones_cls", dut_if.class_idx, 0);

    // Class 2 doubled, class 3 gets +1.0 bias; a second start at edge 50 must be ignored.
    for (int k = 0; k < NI; k++) dut_if.weights[2*NI + k] = 16'h0200;
    dut_if.biases[3] = 16'h0100;
    do_run("mix", 50);
    chk_d(0, 16'h1800);
    chk_d(1, 16'h1800);
    chk_d(2, 16'h3000);
    chk_d(3, 16'h1900);
    chk("mix_cls", dut_if.class_idx, 2);

    fill(16'h7FFF, 16'h7FFF, 16'h0000);
    do_run("satp", -1);
    for (int k = 0; k < NC; k++) chk_d(k, 16'h7FFF);
    chk("satp_cls", dut_if.class_idx, 0);

    fill(16'h7FFF, 16'h8000, 16'h0000);
    do_run("satn", -1);
`ifdef DENSE_RELU_EN
    for (int k = 0; k < NC; k++) chk_d(k, 16'h0000);
`else
    for (int k = 0; k < NC; k++) chk_d(k, 16'h8000);
`endif
    chk("satn_cls", dut_if.class_idx, 0);

    // 1 LSB * 0.5 = 0x80 raw, shifted right by 8 -> 0
    fill(16'h0000, 16'h0000, 16'h0000);
    dut_if.pool_result[0] = 16'h0001;
    dut_if.weights[0]     = 16'h0080;
    do_run("tiny", -1);
    for (int k = 0; k < NC; k++) chk_d(k, 16'h0000);
    chk("tiny_cls", dut_if.class_idx, 0);

    // -0x80 raw floors to -1
    dut_if.weights[0] = 16'hFF80;
    do_run("tneg", -1);
`ifdef DENSE_RELU_EN
    chk_d(0, 16'h0000);
`else
    chk_d(0, 16'hFFFF);
`endif
    chk_d(1, 16'h0000);

    // Reset at edge 30 of a run aborts it; class 0 was already stored at edge 26.
    fill(16'h0100, 16'h0100, 16'h0000);
    for (int k = 0; k < NI; k++) dut_if.weights[2*NI + k] = 16'h0200;
    dut_if.biases[3] = 16'h0100;
    @(negedge clk);
    dut_if.start = 1'b1;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk_d(0, 16'h1800);
    reset = 1'b1;
    #1;
    for (int k = 0; k < NC; k++) chk_d(k, 16'h0000);
    chk("abort_cls", dut_if.class_idx, 0);
    chk("abort_busy", dut_if.busy, 0);
    chk("abort_done", dut_if.done, 0);
    @(negedge clk) reset = 1'b0;
    dcnt = 0;
    repeat (LAT + 10) begin
      @(posedge clk);
      #1;
      if (dut_if.done === 1'b1) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    do_run("after_rst", -1);
    chk_d(2, 16'h3000);
    chk_d(3, 16'h1900);
    chk("after_rst_cls", dut_if.class_idx, 2);

    // start held high: back-to-back runs, one IDLE cycle apart.
    dcnt = 0;
    d_first = -1;
    d_second = -1;
    @(negedge clk);
    dut_if.start = 1'b1;
    @(posedge clk);
    for (int e = 1; e < 300; e++) begin
      @(posedge clk);
      #1;
      if (dut_if.done === 1'b1) begin
        dcnt++;
        if (d_first < 0) d_first = e;
        else if (d_second < 0) d_second = e;
      end
    end
    dut_if.start = 1'b0;
    chk("held_cnt", dcnt, 2);
    chk("held_first", d_first, LAT);
    chk("held_period", d_second - d_first, LAT + 1);
    repeat (LAT + 10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
